// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and window index helper for the Conv2D window feeder.
package conv_pkg;

  localparam int unsigned KERNEL   = 5;
  localparam int unsigned WIN_TAPS = KERNEL * KERNEL;
  localparam int unsigned LB_LINES = KERNEL - 1;

  typedef enum logic [1:0] {
    StAccept,
    StStart,
    StWaitDone,
    StEmit
  } state_e;

  // Row-major tap index inside the 5x5 window.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * KERNEL + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Four-line circular store indexed by column.
// Each write at column col pushes the column one line deeper: tap 0 ends up holding the pixel
// from four lines ago, tap 3 the pixel from the previous line. Reads are combinational.
// Ports:
//   clk     clock
//   wr_en   store wr_data at column col and age that column
//   col     current column (shared by read and write)
//   wr_data incoming pixel
//   taps    LB_LINES pixels of column col, tap 0 oldest, packed low to high
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned COL_W      = $clog2(IMG_W)
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [COL_W-1:0]               col,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic [LB_LINES*DATA_WIDTH-1:0] taps
);

  // Contents are deliberately not reset: a window is only emitted after four full lines.
  logic [DATA_WIDTH-1:0] mem [LB_LINES][IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LB_LINES - 1; i++) begin
        mem[i][col] <= mem[i+1][col];
      end
      mem[LB_LINES-1][col] <= wr_data;
    end
  end

  always_comb begin
    taps = '0;
    for (int i = 0; i < LB_LINES; i++) begin
      taps[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][col];
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Streaming front end for the Conv2D 5x5 MAC engine.
// Accepts a raster pixel stream, builds the 5x5 window from four line buffers plus the live pixel,
// starts Conv2D once per valid (unpadded) window position, waits for done and forwards the result.
// Optional macro CONV_FEEDER_RELU_EN: clamp negative results to zero when latching conv_result.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   frame_clr                   synchronous abort/restart of the current frame
//   pix_data/pix_valid/pix_ready  pixel input stream
//   win_flat                    25 window taps, slice k row-major, k=24 newest pixel
//   conv_enable/conv_done/conv_result  Conv2D start pulse, done and finalOutput
//   res_data/res_valid/res_ready/res_last  result stream, res_last marks the frame's final result
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIXED_POINT = 7,
  parameter int unsigned IMG_W       = 28,
  parameter int unsigned IMG_H       = 28,
  parameter int unsigned RES_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_clr,
  input  logic signed [DATA_WIDTH-1:0]   pix_data,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] win_flat,
  output logic                           conv_enable,
  input  logic                           conv_done,
  input  logic signed [RES_WIDTH-1:0]    conv_result,
  output logic signed [RES_WIDTH-1:0]    res_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           res_last
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(KERNEL - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(KERNEL - 1);

  // FIXED_POINT is only forwarded to Conv2D; checked here so bad configurations fail early.
  if (IMG_W < KERNEL || IMG_H < KERNEL || FIXED_POINT >= DATA_WIDTH) begin : g_param_err
    $error("conv_window_feeder: unsupported parameter set");
  end

  state_e                       state_q, state_d;
  logic [ColW-1:0]              col_q, col_d;
  logic [RowW-1:0]              row_q, row_d;
  logic signed [RES_WIDTH-1:0]  res_q, res_d;
  logic                         last_q, last_d;
  logic                         rdy_en_q;
  logic                         accept;
  logic [DATA_WIDTH-1:0]        win_q [WIN_TAPS];
  logic [LB_LINES*DATA_WIDTH-1:0] lb_taps;
  logic [DATA_WIDTH-1:0]        col_in [KERNEL];

  conv_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .IMG_W     (IMG_W),
    .COL_W     (ColW)
  ) u_line_buffer (
    .clk    (clk),
    .wr_en  (accept),
    .col    (col_q),
    .wr_data(pix_data),
    .taps   (lb_taps)
  );

  // New window column: four buffered lines on top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < LB_LINES; r++) begin
      col_in[r] = lb_taps[r*DATA_WIDTH +: DATA_WIDTH];
    end
    col_in[KERNEL-1] = pix_data;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    res_d       = res_q;
    last_d      = last_q;
    accept      = 1'b0;
    pix_ready   = 1'b0;
    conv_enable = 1'b0;
    res_valid   = 1'b0;
    if (frame_clr) begin
      state_d = StAccept;
      col_d   = '0;
      row_d   = '0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAccept: begin
          pix_ready = rdy_en_q;
          if (pix_valid && rdy_en_q) begin
            accept = 1'b1;
            if (col_q == ColLast) begin
              col_d = '0;
              row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            if (col_q >= ColFirst && row_q >= RowFirst) begin
              state_d = StStart;
              last_d  = (col_q == ColLast) && (row_q == RowLast);
            end
          end
        end
        StStart: begin
          conv_enable = 1'b1;
          state_d     = StWaitDone;
        end
        StWaitDone: begin
          if (conv_done) begin
`ifdef CONV_FEEDER_RELU_EN
            res_d = conv_result[RES_WIDTH-1] ? '0 : conv_result;
`else
            res_d = conv_result;
`endif
            state_d = StEmit;
          end
        end
        StEmit: begin
          res_valid = 1'b1;
          if (res_ready) state_d = StAccept;
        end
        default: state_d = StAccept;
      endcase
    end
  end

  assign res_last = res_valid & last_q;
  assign res_data = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAccept;
      col_q    <= '0;
      row_q    <= '0;
      res_q    <= '0;
      last_q   <= 1'b0;
      rdy_en_q <= 1'b0;
      for (int k = 0; k < WIN_TAPS; k++) win_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      res_q    <= res_d;
      last_q   <= last_d;
      rdy_en_q <= 1'b1;
      // Window only moves on accept, so it is stable while Conv2D is working.
      if (accept) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL - 1; c++) begin
            win_q[win_idx(r, c)] <= win_q[win_idx(r, c + 1)];
          end
          win_q[win_idx(r, KERNEL - 1)] <= col_in[r];
        end
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int k = 0; k < WIN_TAPS; k++) begin
      win_flat[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on an 8x8 image with an all-ones behavioural Conv2D.
module tb_conv_window_feeder;
  localparam int DW = 16;
  localparam int RW = 32;
  localparam int W  = 8;
  localparam int H  = 8;
`ifdef CONV_FEEDER_RELU_EN
  localparam int NegExp = 0;
`else
  localparam int NegExp = -25;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_clr = 1'b0;
  logic signed [DW-1:0] pix_data;
  logic pix_valid;
  logic pix_ready;
  logic [25*DW-1:0] win_flat;
  logic conv_enable;
  logic conv_done;
  logic signed [RW-1:0] conv_result;
  logic signed [RW-1:0] res_data;
  logic res_valid;
  logic res_ready = 1'b1;
  logic res_last;

  conv_window_feeder #(
    .DATA_WIDTH (DW),
    .FIXED_POINT(7),
    .IMG_W      (W),
    .IMG_H      (H),
    .RES_WIDTH  (RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_clr  (frame_clr),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_flat   (win_flat),
    .conv_enable(conv_enable),
    .conv_done  (conv_done),
    .conv_result(conv_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_last   (res_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus controls (main block only)
  int frame_gen = 0;
  bit drv_en = 0;
  bit neg_mode = 0;
  int eng_delay = 0;

  // Monitor state (monitor block only)
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  int vld_cycles = 0;
  int res_cnt = 0;
  logic signed [RW-1:0] res_arr [256];
  bit last_arr [256];

  // Engine state (engine block only)
  int en_cnt = 0;
  int extra_en = 0;
  int win_changed = 0;
  int en_acc [256];
  int en_gap [256];
  logic [DW-1:0] en_w0 [256];
  logic [DW-1:0] en_w24 [256];

  // Pixel source: ramp pix(r,c)=r*8+c or all -1, restarted on each frame_gen change.
  initial begin
    int seen_gen;
    int seen_acc;
    int drv_idx;
    seen_gen = 0;
    seen_acc = 0;
    drv_idx = 0;
    pix_valid = 1'b0;
    pix_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_cnt != seen_acc) begin
        drv_idx += acc_cnt - seen_acc;
        seen_acc = acc_cnt;
      end
      if (frame_gen != seen_gen) begin
        drv_idx = 0;
        seen_gen = frame_gen;
      end
      pix_valid = drv_en && (drv_idx < W * H);
      pix_data = neg_mode ? -16'sd1 : DW'(drv_idx);
    end
  end

  // Handshake monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (res_valid) vld_cycles++;
      if (res_valid && res_ready && res_cnt < 256) begin
        res_arr[res_cnt] = res_data;
        last_arr[res_cnt] = res_last;
        res_cnt++;
      end
    end
  end

  // Behavioural Conv2D with all weights = 1.
  initial begin
    int s;
    int d;
    logic signed [DW-1:0] v;
    logic [25*DW-1:0] snap;
    conv_done = 1'b0;
    conv_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (conv_enable) begin
        s = 0;
        for (int k = 0; k < 25; k++) begin
          v = win_flat[k*DW +: DW];
          s += int'(v);
        end
        snap = win_flat;
        if (en_cnt < 256) begin
          en_acc[en_cnt] = acc_cnt;
          en_gap[en_cnt] = cyc - last_acc_cyc;
          en_w0[en_cnt] = win_flat[DW-1:0];
          en_w24[en_cnt] = win_flat[24*DW +: DW];
        end
        en_cnt++;
        d = eng_delay;
        @(posedge clk);
        #1;
        if (conv_enable) extra_en++;
        for (int i = 0; i < d; i++) begin
          @(posedge clk);
          #1;
          if (conv_enable) extra_en++;
        end
        if (win_flat !== snap) win_changed++;
        conv_done = 1'b1;
        conv_result = s;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        conv_result = 32'h0000_dead;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_res(input int target, input int budget, input string tag);
    int t;
    t = 0;
    while (res_cnt < target && t < budget) begin
      tick(1);
      t++;
    end
    chk({tag, "_done"}, 64'(res_cnt >= target), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int t;
    t = 0;
    while (!res_valid && t < budget) begin
      tick(1);
      t++;
    end
    chk({tag, "_valid"}, 64'(res_valid), 64'd1);
  endtask

  // Ramp result at output (i,j) = 450 + 25*(8i+j); all -1 frame gives NegExp everywhere.
  task automatic chk_frame(input int base, input bit neg, input string tag);
    int bad;
    int lasts;
    int exp_v;
    bad = 0;
    lasts = 0;
    for (int k = 0; k < 16; k++) begin
      exp_v = neg ? NegExp : 450 + 25 * (8 * (k / 4) + (k % 4));
      if (res_arr[base+k] !== exp_v) bad++;
      if (last_arr[base+k]) lasts++;
    end
    chk({tag, "_first"}, 64'(res_arr[base]), neg ? 64'(NegExp) : 64'd450);
    chk({tag, "_values_bad"}, 64'(bad), 64'd0);
    chk({tag, "_last_on_16th"}, 64'(last_arr[base+15]), 64'd1);
    chk({tag, "_last_count"}, 64'(lasts), 64'd1);
  endtask

  initial begin
    int base;
    int eb;
    int ab;
    int a0;
    int v0;
    int wc0;
    int x0;
    int hold_bad;
    logic signed [RW-1:0] d0;

    // Reset values
    tick(3);
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_conv_enable", 64'(conv_enable), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_last", 64'(res_last), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_win_zero", 64'(win_flat == '0), 64'd1);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_pix_ready", 64'(pix_ready), 64'd1);

    // 1 Ramp, back-to-back
    base = res_cnt;
    eb = en_cnt;
    ab = acc_cnt;
    frame_gen++;
    drv_en = 1;
    wait_res(base + 16, 2000, "ramp");
    tick(10);
    chk("ramp_count", 64'(res_cnt - base), 64'd16);
    chk("ramp_en_count", 64'(en_cnt - eb), 64'd16);
    chk("ramp_first_en_pixels", 64'(en_acc[eb] - ab), 64'd37);
    chk("ramp_first_en_gap", 64'(en_gap[eb]), 64'd1);
    chk("ramp_win_slice0", 64'(en_w0[eb]), 64'd0);
    chk("ramp_win_slice24", 64'(en_w24[eb]), 64'd36);
    chk_frame(base, 0, "ramp");

    // 2 Backpressure on the first result
    res_ready = 1'b0;
    base = res_cnt;
    frame_gen++;
    wait_valid(500, "bp");
    d0 = res_data;
    a0 = acc_cnt;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!res_valid || res_data !== d0 || pix_ready) hold_bad++;
    end
    chk("bp_hold_bad", 64'(hold_bad), 64'd0);
    chk("bp_no_accept", 64'(acc_cnt - a0), 64'd0);
    chk("bp_held_data", 64'(d0), 64'd450);
    res_ready = 1'b1;
    wait_res(base + 16, 2000, "bp");
    chk_frame(base, 0, "bp");

    // 3 Slow engine
    eng_delay = 50;
    base = res_cnt;
    eb = en_cnt;
    wc0 = win_changed;
    x0 = extra_en;
    frame_gen++;
    wait_res(base + 16, 4000, "slow");
    tick(5);
    chk("slow_en_count", 64'(en_cnt - eb), 64'd16);
    chk("slow_extra_en", 64'(extra_en - x0), 64'd0);
    chk("slow_win_changed", 64'(win_changed - wc0), 64'd0);
    chk_frame(base, 0, "slow");

    // 4 frame_clr while waiting for done
    base = res_cnt;
    eb = en_cnt;
    frame_gen++;
    begin
      int t;
      t = 0;
      while (en_cnt == eb && t < 500) begin
        tick(1);
        t++;
      end
    end
    chk("clr_saw_enable", 64'(en_cnt > eb), 64'd1);
    tick(3);
    frame_clr = 1'b1;
    drv_en = 0;
    #1;
    chk("clr_pix_ready", 64'(pix_ready), 64'd0);
    chk("clr_conv_enable", 64'(conv_enable), 64'd0);
    tick(1);
    frame_clr = 1'b0;
    v0 = vld_cycles;
    tick(70);
    chk("clr_no_valid", 64'(vld_cycles - v0), 64'd0);
    chk("clr_no_result", 64'(res_cnt - base), 64'd0);
    eng_delay = 0;
    ab = acc_cnt;
    eb = en_cnt;
    frame_gen++;
    drv_en = 1;
    wait_res(base + 16, 2000, "clr_next");
    chk("clr_next_first_en_pixels", 64'(en_acc[eb] - ab), 64'd37);
    chk_frame(base, 0, "clr_next");

    // 5 All pixels = -1
    neg_mode = 1;
    base = res_cnt;
    frame_gen++;
    wait_res(base + 16, 2000, "neg");
    chk_frame(base, 1, "neg");
    neg_mode = 0;

    // 6 Reset asserted in EMIT, then replay the ramp frame
    res_ready = 1'b0;
    frame_gen++;
    wait_valid(500, "rst_emit");
    rst_n = 1'b0;
    drv_en = 0;
    #1;
    chk("rst_emit_res_valid", 64'(res_valid), 64'd0);
    chk("rst_emit_res_data", 64'(res_data), 64'd0);
    chk("rst_emit_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_emit_conv_enable", 64'(conv_enable), 64'd0);
    chk("rst_emit_win_zero", 64'(win_flat == '0), 64'd1);
    tick(2);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick(2);
    base = res_cnt;
    frame_gen++;
    drv_en = 1;
    wait_res(base + 16, 2000, "replay");
    chk_frame(base, 0, "replay");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
